load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 137 +++++++++++++
 tb/tb_load_store_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, drives a fixed-latency DMEM port and returns a held response.
// Optional macro LSU_MISALIGN_TRAP_EN makes misaligned accesses return an error instead of being force-aligned.
module load_store_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic [31:0] daddr,
    output logic [31:0] indata,
    output logic [1:0]  str,
    output logic [1:0]  stw,
    output logic        we,
    input  logic [31:0] outdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_store;
    logic        r_signed;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [2:0]  r_cnt;

    logic [31:0] w_ea;
    logic [31:0] w_ea_aligned;
    logic        w_word;
    logic        w_half;
    logic        w_accept;
    logic        w_trap;
    logic        w_active;
    logic        w_wait_done;
    logic [31:0] w_load_ext;

    // Size code 11 behaves exactly like a word access.
    assign w_ea         = req_base + {{16{req_offset[15]}}, req_offset};
    assign w_word       = req_size[1];
    assign w_half       = (req_size == 2'b01);
    assign w_ea_aligned = w_word ? {w_ea[31:2], 2'b00} :
                          w_half ? {w_ea[31:1], 1'b0}  : w_ea;

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = (w_half && w_ea[0]) || (w_word && (w_ea[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    assign w_accept    = req_valid && req_ready;
    assign w_wait_done = (r_cnt == 3'(MEM_LAT - 1));

    always_comb begin
        w_load_ext = outdata;
        case (r_size)
            2'b00:   w_load_ext = {{24{r_signed & outdata[7]}}, outdata[7:0]};
            2'b01:   w_load_ext = {{16{r_signed & outdata[15]}}, outdata[15:0]};
            default: w_load_ext = outdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_trap ? RESP : ISSUE;
            ISSUE:   w_next = r_store ? RESP : WAIT;
            WAIT:    if (w_wait_done) w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_store  <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
            r_cnt    <= 3'd0;
        end else begin
            if (w_accept) begin
                r_store  <= req_store;
                r_signed <= req_signed;
                r_size   <= req_size;
                r_addr   <= w_ea_aligned;
                r_wdata  <= req_wdata;
                r_rdata  <= 32'd0;
                r_err    <= w_trap;
                r_cnt    <= 3'd0;
            end else if (r_state == WAIT) begin
                if (w_wait_done) begin
                    r_rdata <= w_load_ext;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end
    end

    // DMEM signals are only driven while an access is in flight, so they read as zero otherwise.
    assign w_active   = (r_state == ISSUE) || (r_state == WAIT);
    assign req_ready  = (r_state == IDLE) && rst_n;
    assign daddr      = w_active ? r_addr  : 32'd0;
    assign indata     = w_active ? r_wdata : 32'd0;
    assign str        = w_active ? r_size  : 2'b00;
    assign stw        = w_active ? r_size  : 2'b00;
    assign we         = (r_state == ISSUE) && r_store;
    assign resp_valid = (r_state == RESP);
    assign resp_data  = resp_valid ? r_rdata : 32'd0;
    assign resp_err   = resp_valid && r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses, a monitor pops and compares.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid3 = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_base = 32'd0;
    logic [15:0] req_offset = 16'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] outdata = 32'd0;
    logic        resp_ready = 1'b1;
    logic        resp_ready3 = 1'b1;

    logic        req_ready, we, resp_valid, resp_err;
    logic [31:0] daddr, indata, resp_data;
    logic [1:0]  str, stw;
    logic        req_ready3, we3, resp_valid3, resp_err3;
    logic [31:0] daddr3, indata3, resp_data3;
    logic [1:0]  str3, stw3;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    int          weCount = 0;
    logic [31:0] weAddr = 32'd0;
    logic [31:0] weData = 32'd0;
    logic [1:0]  weStw = 2'b00;
    logic [31:0] addrSeen = 32'd0;
    logic        prevValid = 1'b0;

    load_store_unit #(.MEM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .daddr(daddr), .indata(indata), .str(str), .stw(stw), .we(we),
        .outdata(outdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err)
    );

    load_store_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .daddr(daddr3), .indata(indata3), .str(str3), .stw(stw3), .we(we3),
        .outdata(outdata), .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_data(resp_data3), .resp_err(resp_err3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one request to the MEM_LAT=1 unit and, once accepted, queues its expected response.
    task automatic applyStimulus(input logic store, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] base, input logic [15:0] off, input logic [31:0] wdata,
                                 input logic [31:0] expData, input logic expErr, input int expLat,
                                 input bit push);
        exp_t e;
        bit   got = 1'b0;
        @(posedge clk); #1;
        req_store  = store;
        req_size   = size;
        req_signed = sgn;
        req_base   = base;
        req_offset = off;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("req_accepted", 32'(got), 32'd1);
        if (got && push) begin
            e.data = expData;
            e.err  = expErr;
            e.lat  = expLat;
            e.acc  = cyc;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 50; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clk);
        end
        checkOutput("drain", 32'(sbq.size()), 32'd0);
    endtask

    // Response monitor: latency on the rising edge of resp_valid, payload at the handshake.
    always @(negedge clk) begin
        if (resp_valid && !prevValid) begin
            if (sbq.size() == 0) checkOutput("unexpected_resp", 32'(resp_valid), 32'd0);
            else checkOutput("resp_latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
        end
        if (resp_valid && resp_ready && sbq.size() != 0) begin
            checkOutput("resp_data", resp_data, sbq[0].data);
            checkOutput("resp_err", 32'(resp_err), 32'(sbq[0].err));
            void'(sbq.pop_front());
        end
        prevValid = resp_valid;
    end

    // DMEM side observer.
    always @(negedge clk) begin
        if (we) begin
            weCount++;
            weAddr = daddr;
            weData = indata;
            weStw  = stw;
        end
        if (daddr != 32'd0) addrSeen = daddr;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int acc3;
        int wc;
        bit got;

        // Reset values
        #12;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_we", 32'(we), 32'd0);
        checkOutput("rst_daddr", daddr, 32'd0);
        checkOutput("rst_resp_data", resp_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Store word
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h100, 16'h0004, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b1);
        waitDrain();
        checkOutput("sw_we_count", 32'(weCount), 32'd1);
        checkOutput("sw_daddr", weAddr, 32'h104);
        checkOutput("sw_stw", 32'(weStw), 32'd2);
        checkOutput("sw_indata", weData, 32'hDEADBEEF);

        // Store byte
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h20, 16'h0003, 32'h000000AB, 32'd0, 1'b0, 2, 1'b1);
        waitDrain();
        checkOutput("sb_we_count", 32'(weCount), 32'd2);
        checkOutput("sb_daddr", weAddr, 32'h23);
        checkOutput("sb_stw", 32'(weStw), 32'd0);

        // Byte loads signed/unsigned
        outdata = 32'h000000F0;
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h40, 16'h0000, 32'd0, 32'hFFFFFFF0, 1'b0, 3, 1'b1);
        waitDrain();
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h40, 16'h0000, 32'd0, 32'h000000F0, 1'b0, 3, 1'b1);
        waitDrain();

        // Address wrap-around with signed half load
        outdata  = 32'h00008001;
        addrSeen = 32'd0;
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h2, 16'hFFFC, 32'd0, 32'hFFFF8001, 1'b0, 3, 1'b1);
        waitDrain();
        checkOutput("wrap_daddr", addrSeen, 32'hFFFFFFFE);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h2, 16'hFFFC, 32'd0, 32'h00008001, 1'b0, 3, 1'b1);
        waitDrain();

        // Size 11 acts as word, negative offset
        outdata  = 32'h12345678;
        addrSeen = 32'd0;
        applyStimulus(1'b0, 2'b11, 1'b1, 32'h1000, 16'hFFF8, 32'd0, 32'h12345678, 1'b0, 3, 1'b1);
        waitDrain();
        checkOutput("neg_off_daddr", addrSeen, 32'hFF8);

        // Response held under back-pressure, second request waits for the handshake
        outdata    = 32'h000000A5;
        resp_ready = 1'b0;
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h200, 16'h0000, 32'd0, 32'h000000A5, 1'b0, 3, 1'b1);
        req_store = 1'b1;
        req_size  = 2'b10;
        req_base  = 32'h300;
        req_wdata = 32'h11223344;
        req_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("hold_resp_seen", 32'(got), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold_resp_data", resp_data, 32'h000000A5);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("resp_cycle_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        checkOutput("after_hs_req_ready", 32'(req_ready), 32'd1);
        begin
            exp_t e;
            e.data = 32'd0;
            e.err  = 1'b0;
            e.lat  = 2;
            e.acc  = cyc;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        waitDrain();

        // Reset during a store ISSUE cycle clears we immediately
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h500, 16'h0000, 32'h55AA55AA, 32'd0, 1'b0, 2, 1'b0);
        checkOutput("issue_we", 32'(we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_we", 32'(we), 32'd0);
        checkOutput("async_indata", indata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset during load WAIT aborts with no response
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h600, 16'h0000, 32'd0, 32'd0, 1'b0, 3, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checkOutput("wait_rst_daddr", daddr, 32'd0);
        checkOutput("wait_rst_str", 32'(str), 32'd0);
        checkOutput("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("wait_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        outdata = 32'h0000007F;
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h700, 16'h0001, 32'd0, 32'h0000007F, 1'b0, 3, 1'b1);
        waitDrain();

        // Misaligned accesses
        outdata  = 32'hCAFEF00D;
        addrSeen = 32'd0;
        wc       = weCount;
`ifdef LSU_MISALIGN_TRAP_EN
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h103, 16'h0000, 32'd0, 32'd0, 1'b1, 1, 1'b1);
        waitDrain();
        checkOutput("mis_lw_no_access", addrSeen, 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h101, 16'h0000, 32'h0000BEEF, 32'd0, 1'b1, 1, 1'b1);
        waitDrain();
        checkOutput("mis_sh_no_we", 32'(weCount), 32'(wc));
`else
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h103, 16'h0000, 32'd0, 32'hCAFEF00D, 1'b0, 3, 1'b1);
        waitDrain();
        checkOutput("mis_lw_daddr", addrSeen, 32'h100);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h101, 16'h0000, 32'h0000BEEF, 32'd0, 1'b0, 2, 1'b1);
        waitDrain();
        checkOutput("mis_sh_we_count", 32'(weCount), 32'(wc + 1));
        checkOutput("mis_sh_daddr", weAddr, 32'h100);
        checkOutput("mis_sh_stw", 32'(weStw), 32'd1);
`endif

        // MEM_LAT = 3 instance: signed byte load latency and data
        outdata = 32'h000000F0;
        @(posedge clk); #1;
        req_store  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b1;
        req_base   = 32'h40;
        req_offset = 16'h0000;
        req_valid3 = 1'b1;
        @(negedge clk);
        checkOutput("lat3_req_ready", 32'(req_ready3), 32'd1);
        acc3 = cyc;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid3) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("lat3_resp_seen", 32'(got), 32'd1);
        checkOutput("lat3_latency", 32'(cyc - acc3), 32'd5);
        checkOutput("lat3_resp_data", resp_data3, 32'hFFFFFFF0);
        checkOutput("lat3_resp_err", 32'(resp_err3), 32'd0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
